xaddrgen_wr: RTL

Write-side address generator for a Versat data memory port. It mirrors the read address generator's access pattern: iterations, period, duty, delay, start, shift and incr. Instead of producing read addresses, it consumes a functional-unit result stream and emits registered write strobes, addresses and data. It sits between a functional unit's output and the write port of an `xmem` bank. It is configured and started by the same init/run controls.

---
 rtl/xaddrgen_wr.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/xaddrgen_wr.sv
// xaddrgen_wr: write-side Versat address generator. It turns a functional-unit result stream
// into registered write strobes, addresses and data, following the read generator's access pattern.
`default_nettype none

`ifndef MEM_ADDR_W
`define MEM_ADDR_W 10
`endif
`ifndef PERIOD_W
`define PERIOD_W 10
`endif
`ifndef DATA_W
`define DATA_W 32
`endif

module xaddrgen_wr #(
  parameter int MEM_ADDR_W = `MEM_ADDR_W,
  parameter int PERIOD_W   = `PERIOD_W,
  parameter int DATA_W     = `DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         init,
  input  logic                         run,
  input  logic                         pause,
  input  logic [MEM_ADDR_W-1:0]        iterations,
  input  logic [PERIOD_W-1:0]          period,
  input  logic [PERIOD_W-1:0]          duty,
  input  logic [PERIOD_W-1:0]          delay,
  input  logic [MEM_ADDR_W-1:0]        start,
  input  logic signed [MEM_ADDR_W-1:0] shift,
  input  logic signed [MEM_ADDR_W-1:0] incr,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         mem_we,
  output logic [MEM_ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]            mem_data,
  output logic                         done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  localparam logic [PERIOD_W-1:0]   P_ONE = 1;
  localparam logic [MEM_ADDR_W-1:0] A_ONE = 1;

  state_t                  state_q, state_d;
  logic [MEM_ADDR_W-1:0]   addr_q, addr_d;
  logic [MEM_ADDR_W-1:0]   iter_q, iter_d;
  logic [PERIOD_W-1:0]     per_cnt_q, per_cnt_d;
  logic [PERIOD_W-1:0]     dly_q, dly_d;
  logic                    mem_we_q;
  logic [MEM_ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]       mem_data_q;
  logic                    done_q;

  logic [PERIOD_W-1:0]     eff_period;
  logic [PERIOD_W-1:0]     eff_duty;
  logic [MEM_ADDR_W-1:0]   eff_iter;
  logic                    slot_wr;
  logic                    slot_last;
  logic [MEM_ADDR_W-1:0]   incr_term;
  logic [MEM_ADDR_W-1:0]   shift_term;

  // Degenerate configs are normalised so period=0 acts as 1 and duty never exceeds the period.
  assign eff_period = (period == '0) ? P_ONE : period;
  assign eff_duty   = (duty > eff_period) ? eff_period : duty;
  assign eff_iter   = (iterations == '0) ? A_ONE : iterations;
  assign slot_wr    = (state_q == S_RUN) && (per_cnt_q < eff_duty);
  assign slot_last  = (per_cnt_q == (eff_period - P_ONE));
  assign incr_term  = slot_wr ? incr : '0;
  assign shift_term = slot_last ? shift : '0;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    iter_d    = iter_q;
    per_cnt_d = per_cnt_q;
    dly_d     = dly_q;
    case (state_q)
      S_IDLE: begin
        if (init) begin
          addr_d    = start;
          iter_d    = A_ONE;
          per_cnt_d = '0;
        end
        if (run) begin
          if (delay != '0) begin
            state_d = S_DELAY;
            dly_d   = delay;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_DELAY: begin
        if (!pause) begin
          if (dly_q <= P_ONE) begin
            state_d   = S_RUN;
            per_cnt_d = '0;
            dly_d     = '0;
          end else begin
            dly_d = dly_q - P_ONE;
          end
        end
      end
      S_RUN: begin
        if (!pause) begin
          addr_d = addr_q + incr_term + shift_term;
          if (slot_last) begin
            per_cnt_d = '0;
            iter_d    = iter_q + A_ONE;
            // >= rather than == so a stale count from a run without init still terminates.
            if (iter_q >= eff_iter) begin
              state_d = S_IDLE;
            end
          end else begin
            per_cnt_d = per_cnt_q + P_ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      iter_q    <= '0;
      per_cnt_q <= '0;
      dly_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      iter_q    <= iter_d;
      per_cnt_q <= per_cnt_d;
      dly_q     <= dly_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      done_q     <= 1'b1;
    end else begin
      if ((state_q == S_RUN) && !pause) begin
        mem_we_q   <= slot_wr;
        mem_addr_q <= addr_q;
        mem_data_q <= in_data;
      end else begin
        mem_we_q <= 1'b0;
      end
      done_q <= (state_d == S_IDLE);
    end
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign done     = done_q;

endmodule

`default_nettype wire
